// File: rtl/contador_checker.sv
// contador_checker
// Response monitor for the ENB/MODO/D -> Q/RCO counter family. It keeps a
// cycle-accurate reference of the counter. It compares the DUT Q (and
// optionally RCO) every cycle, counts mismatches and captures the first
// failure.
// Optional feature macro: CONTADOR_CHK_RCO_EN
//   defined   -> a mismatch is (Q != EXP_Q) or (RCO != EXP_RCO)
//   undefined -> only Q is compared, and there is no EXP_RCO register
// ECW is assumed to be 32 or less, so that ERR_LIMIT can be compared directly.
module contador_checker #(
   parameter int WIDTH     = 4,
   parameter int ECW       = 8,
   parameter int ERR_LIMIT = 0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENB,
   input  logic [1:0]       MODO,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] Q,
   input  logic             RCO,
   output logic             SYNCED,
   output logic             ERROR,
   output logic             ERR_STICKY,
   output logic [ECW-1:0]   ERR_CNT,
   output logic [ECW-1:0]   CHK_CNT,
   output logic [WIDTH-1:0] FIRST_EXP_Q,
   output logic [WIDTH-1:0] FIRST_OBS_Q,
   output logic [1:0]       STATE
);

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'b00,
      ST_CHECK  = 2'b01,
      ST_HALT   = 2'b10
   } state_t;

   localparam logic [ECW-1:0]   CNT_MAX  = {ECW{1'b1}};
   localparam int unsigned      LIMIT_U  = ERR_LIMIT;

   state_t           r_state;
   logic [WIDTH-1:0] r_exp_q;
   logic             r_error;
   logic             r_sticky;
   logic [ECW-1:0]   r_err_cnt;
   logic [ECW-1:0]   r_chk_cnt;
   logic [WIDTH-1:0] r_first_exp_q;
   logic [WIDTH-1:0] r_first_obs_q;

   logic [WIDTH-1:0] w_next_q;
   logic             w_load;
   logic             w_mismatch;
   logic [ECW-1:0]   w_err_cnt_inc;
   logic [ECW-1:0]   w_chk_cnt_inc;
   logic             w_limit_hit;

`ifdef CONTADOR_CHK_RCO_EN
   logic             r_exp_rco;
   logic             w_next_rco;
`else
   logic             w_unused_rco;
   assign w_unused_rco = RCO;
`endif

   assign w_load = ENB && (MODO == 2'b11);

   // Saturating increments: the counters stop at all-ones and never wrap.
   assign w_err_cnt_inc = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + {{(ECW-1){1'b0}}, 1'b1};
   assign w_chk_cnt_inc = (r_chk_cnt == CNT_MAX) ? r_chk_cnt : r_chk_cnt + {{(ECW-1){1'b0}}, 1'b1};

   // HALT is requested when the error count after this mismatch equals the limit.
   assign w_limit_hit = (LIMIT_U != 32'd0) && (32'(w_err_cnt_inc) == LIMIT_U);

   // Reference counter: next expected Q from the sampled command.
   always_comb begin
      w_next_q = r_exp_q;
      if (ENB) begin
         case (MODO)
            2'b00:   w_next_q = r_exp_q + WIDTH'(1'b1);
            2'b01:   w_next_q = r_exp_q - WIDTH'(1'b1);
            2'b10:   w_next_q = r_exp_q - WIDTH'(2'd3);
            2'b11:   w_next_q = D;
            default: w_next_q = r_exp_q;
         endcase
      end else begin
         w_next_q = r_exp_q;
      end
   end

`ifdef CONTADOR_CHK_RCO_EN
   // Reference carry/borrow: set only on the wrap or borrow step of the command.
   always_comb begin
      w_next_rco = 1'b0;
      if (ENB) begin
         case (MODO)
            2'b00:   w_next_rco = (r_exp_q == {WIDTH{1'b1}});
            2'b01:   w_next_rco = (r_exp_q == {WIDTH{1'b0}});
            2'b10:   w_next_rco = (r_exp_q < WIDTH'(2'd3));
            2'b11:   w_next_rco = 1'b0;
            default: w_next_rco = 1'b0;
         endcase
      end else begin
         w_next_rco = 1'b0;
      end
   end

   assign w_mismatch = (Q != r_exp_q) || (RCO != r_exp_rco);
`else
   assign w_mismatch = (Q != r_exp_q);
`endif

   // Checker FSM: sync on the first load, then compare every edge until reset or halt.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state       <= ST_UNSYNC;
         r_exp_q       <= {WIDTH{1'b0}};
         r_error       <= 1'b0;
         r_sticky      <= 1'b0;
         r_err_cnt     <= {ECW{1'b0}};
         r_chk_cnt     <= {ECW{1'b0}};
         r_first_exp_q <= {WIDTH{1'b0}};
         r_first_obs_q <= {WIDTH{1'b0}};
`ifdef CONTADOR_CHK_RCO_EN
         r_exp_rco     <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_UNSYNC: begin
               r_error <= 1'b0;
               if (w_load) begin
                  r_exp_q <= D;
`ifdef CONTADOR_CHK_RCO_EN
                  r_exp_rco <= 1'b0;
`endif
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               // Compare first, then advance the model. The model never resyncs to the DUT.
               r_chk_cnt <= w_chk_cnt_inc;
               r_error   <= w_mismatch;
               r_exp_q   <= w_next_q;
`ifdef CONTADOR_CHK_RCO_EN
               r_exp_rco <= w_next_rco;
`endif
               if (w_mismatch) begin
                  r_err_cnt <= w_err_cnt_inc;
                  r_sticky  <= 1'b1;
                  if (!r_sticky) begin
                     r_first_exp_q <= r_exp_q;
                     r_first_obs_q <= Q;
                  end
                  if (w_limit_hit) begin
                     r_state <= ST_HALT;
                  end
               end
            end
            ST_HALT: begin
               r_error <= 1'b0;
            end
            default: begin
               r_state <= ST_UNSYNC;
               r_error <= 1'b0;
            end
         endcase
      end
   end

   assign SYNCED      = (r_state == ST_CHECK);
   assign ERROR       = r_error;
   assign ERR_STICKY  = r_sticky;
   assign ERR_CNT     = r_err_cnt;
   assign CHK_CNT     = r_chk_cnt;
   assign FIRST_EXP_Q = r_first_exp_q;
   assign FIRST_OBS_Q = r_first_obs_q;
   assign STATE       = r_state;

endmodule

// File: tb/tb_contador_checker.sv
// Bench for contador_checker (WIDTH=4, ECW=8).
// A behavioural counter acts as the watched DUT, and faults can be injected into it.
// Two checkers observe it: one never halts (ERR_LIMIT=0), and one halts
// when its error count reaches 3.
// Honours CONTADOR_CHK_RCO_EN in the model.
module tb_contador_checker;

   localparam int W = 4;
   localparam int M = 16;

   logic       clk;
   logic       rst;
   logic       enb;
   logic [1:0] modo;
   logic [3:0] d;

   // Watched counter and its fault controls.
   logic [3:0] cq;
   logic       crco;
   logic       f_bit0;
   logic       f_rco0;
   logic [3:0] q_obs;
   logic       rco_obs;

   logic       synced_w [2];
   logic       error_w  [2];
   logic       sticky_w [2];
   logic [7:0] err_w    [2];
   logic [7:0] chk_w    [2];
   logic [3:0] fe_w     [2];
   logic [3:0] fo_w     [2];
   logic [1:0] state_w  [2];

   int n_checks = 0;
   int n_errors = 0;

   assign q_obs   = f_bit0 ? {cq[3:1], 1'b0} : cq;
   assign rco_obs = f_rco0 ? 1'b0 : crco;

   contador_checker #(.WIDTH(W), .ECW(8), .ERR_LIMIT(0)) dut (
      .CLK(clk), .RESET(rst), .ENB(enb), .MODO(modo), .D(d), .Q(q_obs), .RCO(rco_obs),
      .SYNCED(synced_w[0]), .ERROR(error_w[0]), .ERR_STICKY(sticky_w[0]),
      .ERR_CNT(err_w[0]), .CHK_CNT(chk_w[0]), .FIRST_EXP_Q(fe_w[0]),
      .FIRST_OBS_Q(fo_w[0]), .STATE(state_w[0])
   );

   contador_checker #(.WIDTH(W), .ECW(8), .ERR_LIMIT(3)) dut_h (
      .CLK(clk), .RESET(rst), .ENB(enb), .MODO(modo), .D(d), .Q(q_obs), .RCO(rco_obs),
      .SYNCED(synced_w[1]), .ERROR(error_w[1]), .ERR_STICKY(sticky_w[1]),
      .ERR_CNT(err_w[1]), .CHK_CNT(chk_w[1]), .FIRST_EXP_Q(fe_w[1]),
      .FIRST_OBS_Q(fo_w[1]), .STATE(state_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int nq(input int q, input int e, input int m, input int dd);
      if (e == 0) return q;
      case (m)
         0: return (q + 1) % M;
         1: return (q + M - 1) % M;
         2: return (q + M - 3) % M;
         default: return dd;
      endcase
   endfunction

   function automatic int nrco(input int q, input int e, input int m);
      if (e == 0) return 0;
      case (m)
         0: return (q == M - 1) ? 1 : 0;
         1: return (q == 0) ? 1 : 0;
         2: return (q < 3) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   // Watched counter: follows the command convention exactly.
   always @(posedge clk) begin
      if (rst) begin
         cq   <= 4'd0;
         crco <= 1'b0;
      end else begin
         cq   <= 4'(nq(int'(cq), int'(enb), int'(modo), int'(d)));
         crco <= 1'(nrco(int'(cq), int'(enb), int'(modo)));
      end
   end

   // Edge samples for the model.
   logic       s_valid = 1'b0;
   logic       s_rst, s_enb, s_rco;
   logic [1:0] s_modo;
   logic [3:0] s_d, s_q;
   always @(posedge clk) begin
      s_valid <= 1'b1;
      s_rst   <= rst;
      s_enb   <= enb;
      s_modo  <= modo;
      s_d     <= d;
      s_q     <= q_obs;
      s_rco   <= rco_obs;
   end

   task automatic chk(input string name, input int k, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, k, act, exp, $time);
      end
   endtask

   // Checker model: the state is 0 (unsync), 1 (check) or 2 (halt), and the counts are plain ints.
   int m_state [2], m_exp [2], m_exprco [2], m_err [2], m_chk [2];
   int m_sticky [2], m_fe [2], m_fo [2], m_error [2];
   int lim [2];
   int mism;

   initial begin
      lim[0] = 0;
      lim[1] = 3;
      for (int k = 0; k < 2; k++) begin
         m_state[k] = 0; m_exp[k] = 0; m_exprco[k] = 0; m_err[k] = 0; m_chk[k] = 0;
         m_sticky[k] = 0; m_fe[k] = 0; m_fo[k] = 0; m_error[k] = 0;
      end
      forever begin
         @(negedge clk);
         if (s_valid) begin
            for (int k = 0; k < 2; k++) begin
               if (s_rst) begin
                  m_state[k] = 0; m_exp[k] = 0; m_exprco[k] = 0; m_err[k] = 0; m_chk[k] = 0;
                  m_sticky[k] = 0; m_fe[k] = 0; m_fo[k] = 0; m_error[k] = 0;
               end else if (m_state[k] == 1) begin
                  mism = (int'(s_q) != m_exp[k]) ? 1 : 0;
`ifdef CONTADOR_CHK_RCO_EN
                  if (int'(s_rco) != m_exprco[k]) mism = 1;
`endif
                  m_chk[k]   = (m_chk[k] < 255) ? m_chk[k] + 1 : 255;
                  m_error[k] = mism;
                  if (mism == 1) begin
                     if (m_sticky[k] == 0) begin
                        m_fe[k] = m_exp[k];
                        m_fo[k] = int'(s_q);
                     end
                     m_sticky[k] = 1;
                     m_err[k] = (m_err[k] < 255) ? m_err[k] + 1 : 255;
                     if (lim[k] != 0 && m_err[k] == lim[k]) m_state[k] = 2;
                  end
                  m_exprco[k] = nrco(m_exp[k], int'(s_enb), int'(s_modo));
                  m_exp[k]    = nq(m_exp[k], int'(s_enb), int'(s_modo), int'(s_d));
               end else if (m_state[k] == 0) begin
                  m_error[k] = 0;
                  if (s_enb && s_modo == 2'b11) begin
                     m_exp[k] = int'(s_d);
                     m_exprco[k] = 0;
                     m_state[k] = 1;
                  end
               end else begin
                  m_error[k] = 0;
               end
               chk("STATE",       k, int'(state_w[k]),  m_state[k]);
               chk("SYNCED",      k, int'(synced_w[k]), (m_state[k] == 1) ? 1 : 0);
               chk("ERROR",       k, int'(error_w[k]),  m_error[k]);
               chk("ERR_STICKY",  k, int'(sticky_w[k]), m_sticky[k]);
               chk("ERR_CNT",     k, int'(err_w[k]),    m_err[k]);
               chk("CHK_CNT",     k, int'(chk_w[k]),    m_chk[k]);
               chk("FIRST_EXP_Q", k, int'(fe_w[k]),     m_fe[k]);
               chk("FIRST_OBS_Q", k, int'(fo_w[k]),     m_fo[k]);
            end
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [3:0] dd);
      rst  = r;
      enb  = e;
      modo = m;
      d    = dd;
      @(posedge clk);
      #1;
   endtask

   int seq10 [6];
   int rco10 [6];

   // Directed stimulus with hand-computed literal expectations.
   initial begin
      seq10[0] = 13; seq10[1] = 10; seq10[2] = 7; seq10[3] = 4; seq10[4] = 1; seq10[5] = 14;
      rco10[0] = 1;  rco10[1] = 0;  rco10[2] = 0; rco10[3] = 0; rco10[4] = 0; rco10[5] = 1;
      f_bit0 = 1'b0;
      f_rco0 = 1'b0;

      // Reset, load 0, then up-count 17 times.
      step(1'b1, 1'b0, 2'b00, 4'd0);
      chk("lit_reset_state", 0, int'(state_w[0]), 0);
      chk("lit_reset_chk",   0, int'(chk_w[0]), 0);
      step(1'b0, 1'b1, 2'b11, 4'd0);
      chk("lit_synced", 0, int'(synced_w[0]), 1);
      for (int i = 0; i < 17; i++) begin
         step(1'b0, 1'b1, 2'b00, 4'd0);
         if (i == 15) chk("lit_up_wrap_rco", 0, int'(crco), 1);
      end
      chk("lit_up_chk17", 0, int'(chk_w[0]), 17);
      chk("lit_up_err0",  0, int'(err_w[0]), 0);

      // Load 15, then down-count 16 times.
      step(1'b0, 1'b1, 2'b11, 4'd15);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 2'b01, 4'd0);
         chk("lit_dn_rco", 0, int'(crco), (i == 15) ? 1 : 0);
      end

      // Load 0, then step down by 3 six times.
      step(1'b0, 1'b1, 2'b11, 4'd0);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 2'b10, 4'd0);
         chk("lit_m10_q",   0, int'(cq), seq10[i]);
         chk("lit_m10_rco", 0, int'(crco), rco10[i]);
      end
      step(1'b0, 1'b0, 2'b00, 4'd0);
      chk("lit_m10_err0", 0, int'(err_w[0]), 0);

      // Fault: Q bit0 stuck at 0 during the up-count, with a halting checker alongside.
      step(1'b1, 1'b0, 2'b00, 4'd0);
      f_bit0 = 1'b1;
      step(1'b0, 1'b1, 2'b11, 4'd0);
      step(1'b0, 1'b1, 2'b00, 4'd0);
      chk("lit_f_err_first0", 0, int'(error_w[0]), 0);
      step(1'b0, 1'b1, 2'b00, 4'd0);
      chk("lit_f_err_pulse", 0, int'(error_w[0]), 1);
      chk("lit_f_sticky",    0, int'(sticky_w[0]), 1);
      chk("lit_f_first_exp", 0, int'(fe_w[0]), 1);
      chk("lit_f_first_obs", 0, int'(fo_w[0]), 0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'b00, 4'd0);
      chk("lit_f_err5",   0, int'(err_w[0]), 5);
      chk("lit_h_state",  1, int'(state_w[1]), 2);
      chk("lit_h_err3",   1, int'(err_w[1]), 3);
      chk("lit_h_chk6",   1, int'(chk_w[1]), 6);
      step(1'b1, 1'b1, 2'b00, 4'd0);
      chk("lit_h_rst_state", 1, int'(state_w[1]), 0);
      chk("lit_h_rst_err",   1, int'(err_w[1]), 0);
      chk("lit_h_rst_fe",    1, int'(fe_w[1]), 0);
      chk("lit_h_rst_stk",   1, int'(sticky_w[1]), 0);
      f_bit0 = 1'b0;

      // Up-count with no load: the checker stays unsynced.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b00, 4'd0);
      chk("lit_nosync_state", 0, int'(state_w[0]), 0);
      chk("lit_nosync_chk",   0, int'(chk_w[0]), 0);

      // RCO stuck at 0 across the 15 -> 0 wrap.
      f_rco0 = 1'b1;
      step(1'b0, 1'b1, 2'b11, 4'd14);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b00, 4'd0);
`ifdef CONTADOR_CHK_RCO_EN
      chk("lit_rco_err", 0, int'(err_w[0]), 1);
`else
      chk("lit_rco_err", 0, int'(err_w[0]), 0);
`endif
      f_rco0 = 1'b0;

      // Saturation of both counters.
      step(1'b1, 1'b0, 2'b00, 4'd0);
      f_bit0 = 1'b1;
      step(1'b0, 1'b1, 2'b11, 4'd0);
      for (int i = 0; i < 600; i++) step(1'b0, 1'b1, 2'b00, 4'd0);
      chk("lit_sat_err", 0, int'(err_w[0]), 255);
      chk("lit_sat_chk", 0, int'(chk_w[0]), 255);
      chk("lit_sat_h_err", 1, int'(err_w[1]), 3);
      f_bit0 = 1'b0;
      step(1'b0, 1'b0, 2'b00, 4'd0);
      @(negedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/contador_checker.md
Name: contador_checker

Overview:
- Self-checking response monitor for the ENB/MODO/D -> Q/RCO counter register family (4-bit and 16-bit builds).
- Sits beside the counter DUT and watches the same ENB, MODO and D the stimulus side drives, plus the Q and RCO the DUT returns.
- Keeps a cycle-accurate reference model, compares every cycle, counts mismatches and captures the first failure.
- Synthesizable, so it can also run on-chip as a built-in monitor.

Parameters:
- WIDTH, 4, counter data width (16 for the 16-bit build).
- ECW, 8, width of the error and check counters.
- ERR_LIMIT, 0, error count that forces HALT; 0 means never halt.

Ports:
- CLK  input  1  clock, all logic on the rising edge.
- RESET  input  1  reset, synchronous, active-high.
- ENB  input  1  DUT enable, as driven to the DUT.
- MODO  input  2  DUT mode: 00 up +1, 01 down -1, 10 down -3, 11 parallel load.
- D  input  WIDTH  DUT parallel-load data.
- Q  input  WIDTH  DUT count output.
- RCO  input  1  DUT ripple carry/borrow output.
- SYNCED  output  1  reference model is valid and checking is active.
- ERROR  output  1  one-cycle pulse on each mismatch.
- ERR_STICKY  output  1  set on the first mismatch; cleared only by RESET.
- ERR_CNT  output  ECW  mismatch count, saturating.
- CHK_CNT  output  ECW  number of compared cycles, saturating.
- FIRST_EXP_Q  output  WIDTH  expected Q at the first mismatch.
- FIRST_OBS_Q  output  WIDTH  observed Q at the first mismatch.
- STATE  output  2  00 UNSYNC, 01 CHECK, 10 HALT.

Behaviour:
- Reset: synchronous and active-high. On a clock edge with RESET=1, every output and internal register goes to 0 and STATE=UNSYNC. RESET has priority over every other event, including mid-operation.
- DUT model (the convention being checked). On edge n with ENB=1:
  - MODO=00: Q<=Q+1; RCO<=1 only when Q was all-ones (wrap to 0).
  - MODO=01: Q<=Q-1; RCO<=1 only when Q was 0 (wrap to all-ones).
  - MODO=10: Q<=Q-3 mod 2^WIDTH; RCO<=1 when Q<3 (borrow).
  - MODO=11: Q<=D; RCO<=0.
  - With ENB=0: Q holds and RCO<=0.
- Reference registers EXP_Q and EXP_RCO apply these rules to the sampled ENB/MODO/D. All arithmetic is WIDTH bits, modulo 2^WIDTH.
- Compare timing: on edge n the checker compares the DUT's Q/RCO (the result of the command at edge n-1) against EXP_Q/EXP_RCO (registered at edge n-1). It then updates EXP_* from the command at edge n. Latency from command to verdict is 1 cycle. ERROR is registered, so it goes high in the cycle after the compare edge.
- UNSYNC state:
  - No compares take place; ERROR stays 0.
  - On an edge with ENB=1 and MODO=11: EXP_Q<=D and EXP_RCO<=0, then go to CHECK. Compares start on the next edge.
  - Any other command leaves the state in UNSYNC.
- CHECK state:
  - Every edge is a compare and increments CHK_CNT, saturating at all-ones.
  - Mismatch: ERROR=1, ERR_CNT+1 (saturating), ERR_STICKY=1.
  - On the first mismatch only (ERR_STICKY was 0), capture FIRST_EXP_Q/FIRST_OBS_Q.
  - After a mismatch, EXP_* keeps following the model rules; it does not resync to the DUT.
  - A load (ENB=1, MODO=11) in CHECK is still compared first and then reloads EXP_Q from D.
- HALT state:
  - Entered on the edge where ERR_CNT reaches ERR_LIMIT, when ERR_LIMIT is nonzero.
  - No further compares; ERROR=0; all counters and captures freeze.
  - Only RESET exits HALT.
- SYNCED=1 exactly when STATE=CHECK.
- Saturation: at all-ones, ERR_CNT and CHK_CNT hold; they never wrap.
- Simultaneous events:
  - A mismatch on the load edge counts.
  - If the first mismatch and reaching ERR_LIMIT happen on the same edge, both the capture and the HALT transition take effect.

Optional Feature:
- Macro: CONTADOR_CHK_RCO_EN.
- Defined: a mismatch is (Q != EXP_Q) OR (RCO != EXP_RCO).
- Undefined: only Q is compared; RCO is ignored, and the EXP_RCO logic is removed from the build.
- The reset value of EXP_RCO is 0 in both builds.

Test Plan:
- WIDTH=4, RESET 1 cycle; ENB=1, MODO=11, D=0000; then MODO=00 for 17 cycles with a correct DUT -> SYNCED=1 from cycle 2; Q wraps 1111->0000 with RCO=1 for that one cycle; ERR_CNT=0; CHK_CNT=17.
- Load D=1111, then MODO=01 for 16 cycles -> RCO=1 only on the 0000->1111 step; no ERROR.
- Load D=0000, then MODO=10 -> expected sequence 1101, 1010, 0111, 0100, 0001, 1110; RCO=1 on 0000->1101 and 0001->1110; no errors.
- Faulty DUT with Q bit0 forced to 0 during up-count from 0000 -> ERROR pulses first when EXP_Q=0001; FIRST_EXP_Q=0001, FIRST_OBS_Q=0000; ERR_STICKY=1.
- ERR_LIMIT=3 with the same faulty DUT -> STATE=HALT after the 3rd error; ERR_CNT stays 3 and CHK_CNT freezes. RESET mid-HALT -> all outputs 0 and STATE=UNSYNC.
- MODO=00 with no load after reset -> remains UNSYNC; ERROR never asserts; CHK_CNT=0.
- With CONTADOR_CHK_RCO_EN defined and RCO stuck at 0 -> ERROR on the wrap cycle only.
